// File: rtl/mem_bus_arbiter.sv
// Arbitrates the shared data/peripheral bus between the CPU MEM-stage port and a DMA port.
// Define MEM_BUS_TIMEOUT_EN to abort transactions that wait too long for mem_ready.
module mem_bus_arbiter #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned MAX_BURST      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic              dma_lock,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        grant,
    output logic              bus_err
);
    localparam int unsigned WaitW  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
`ifdef MEM_BUS_TIMEOUT_EN
    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_W-1:0] AbortData = DATA_W'(32'hDEADBEEF);
`endif

    if (STARVE_LIMIT < 1 || MAX_BURST < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("mem_bus_arbiter: STARVE_LIMIT, MAX_BURST and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {StIdle, StCpuXfer, StDmaXfer} state_e;

    state_e              state_q, state_d;
    logic [WaitW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [BurstW-1:0]   burst_cnt_q, burst_cnt_d;
    logic                last_dma_q, last_dma_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [1:0]          grant_q, grant_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
    logic                bus_err_q, bus_err_d;
`ifdef MEM_BUS_TIMEOUT_EN
    logic [TimerW-1:0]   timer_q, timer_d;
`endif

    logic                cpu_elig, dma_elig, dma_pref, dma_win;
    logic                xfer_done;
    logic [DATA_W-1:0]   xfer_data;

    // A requester acked this cycle is still holding the old request, so mask it.
    assign cpu_elig = cpu_req & ~cpu_ack_q;
    assign dma_elig = dma_req & ~dma_ack_q;
    assign dma_pref = (wait_cnt_q == WaitW'(STARVE_LIMIT)) |
                      (dma_lock & last_dma_q & (burst_cnt_q < BurstW'(MAX_BURST)));
    assign dma_win  = dma_elig & (dma_pref | ~cpu_elig);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        burst_cnt_d = burst_cnt_q;
        last_dma_d  = last_dma_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_d     = grant_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        bus_err_d   = 1'b0;
        xfer_done   = 1'b0;
        xfer_data   = mem_rdata;
`ifdef MEM_BUS_TIMEOUT_EN
        timer_d     = timer_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef MEM_BUS_TIMEOUT_EN
                timer_d = '0;
`endif
                if (dma_win) begin
                    state_d     = StDmaXfer;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dma_we;
                    mem_addr_d  = dma_addr;
                    mem_wdata_d = dma_wdata;
                    grant_d     = 2'b10;
                    last_dma_d  = 1'b1;
                    wait_cnt_d  = '0;
                    if (!dma_lock) begin
                        burst_cnt_d = '0;
                    end else if (burst_cnt_q < BurstW'(MAX_BURST)) begin
                        burst_cnt_d = burst_cnt_q + 1'b1;
                    end
                end else if (cpu_elig) begin
                    state_d     = StCpuXfer;
                    mem_req_d   = 1'b1;
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    grant_d     = 2'b01;
                    last_dma_d  = 1'b0;
                    burst_cnt_d = '0;
                    if (dma_elig && wait_cnt_q != WaitW'(STARVE_LIMIT)) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end
            end
            StCpuXfer, StDmaXfer: begin
                if (mem_ready) begin
                    xfer_done = 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
                end else if (timer_q == TimerW'(TIMEOUT_CYCLES - 1)) begin
                    xfer_done = 1'b1;
                    xfer_data = AbortData;
                    bus_err_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
                if (xfer_done) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    grant_d   = 2'b00;
                    if (state_q == StCpuXfer) begin
                        cpu_ack_d   = 1'b1;
                        cpu_rdata_d = xfer_data;
                    end else begin
                        dma_ack_d   = 1'b1;
                        dma_rdata_d = xfer_data;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
            last_dma_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            grant_q     <= 2'b00;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            bus_err_q   <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
            timer_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            last_dma_q  <= last_dma_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            grant_q     <= grant_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            bus_err_q   <= bus_err_d;
`ifdef MEM_BUS_TIMEOUT_EN
            timer_q     <= timer_d;
`endif
        end
    end

    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_ack   = dma_ack_q;
    assign dma_rdata = dma_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised and directed bench for mem_bus_arbiter against a transaction-level reference model.
// Define MEM_BUS_TIMEOUT_EN here too when the DUT is built with the timeout feature.
module tb_mem_bus_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SL = 4;
    localparam int MB = 8;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock, mem_ready;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata, mem_rdata;
    logic [DW-1:0] cpu_rdata, dma_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          cpu_ack, cpu_stall, dma_ack, mem_req, mem_we, bus_err;
    logic [1:0]    grant;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)
    ) u_dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .grant(grant), .bus_err(bus_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: owner 0 = bus free, 1 = CPU transaction, 2 = DMA transaction.
    int            m_owner, m_wait, m_burst, m_timer;
    bit            m_last_dma, m_cpu_ack, m_dma_ack, m_bus_err, m_mem_req, m_mem_we;
    logic [AW-1:0] m_mem_addr;
    logic [DW-1:0] m_mem_wdata, m_cpu_rdata, m_dma_rdata;
    logic [1:0]    m_grant;

    task automatic model_reset();
        m_owner = 0; m_wait = 0; m_burst = 0; m_timer = 0; m_last_dma = 0;
        m_cpu_ack = 0; m_dma_ack = 0; m_bus_err = 0; m_mem_req = 0; m_mem_we = 0;
        m_mem_addr = '0; m_mem_wdata = '0; m_cpu_rdata = '0; m_dma_rdata = '0; m_grant = 2'b00;
    endtask

    task automatic finish_xfer(input logic [DW-1:0] data);
        if (m_owner == 1) begin
            m_cpu_ack = 1; m_cpu_rdata = data;
        end else begin
            m_dma_ack = 1; m_dma_rdata = data;
        end
        m_owner = 0; m_mem_req = 0; m_grant = 2'b00;
    endtask

    // Called just after a rising edge while inputs still hold their pre-edge values.
    task automatic model_advance();
        bit ce, de;
        ce = cpu_req && !m_cpu_ack;
        de = dma_req && !m_dma_ack;
        m_cpu_ack = 0; m_dma_ack = 0; m_bus_err = 0;
        if (m_owner == 0) begin
            m_timer = 0;
            if (de && (m_wait == SL || (dma_lock && m_last_dma && m_burst < MB) || !ce)) begin
                m_owner = 2; m_grant = 2'b10; m_mem_req = 1;
                m_mem_we = dma_we; m_mem_addr = dma_addr; m_mem_wdata = dma_wdata;
                m_wait = 0; m_last_dma = 1;
                m_burst = dma_lock ? ((m_burst < MB) ? m_burst + 1 : MB) : 0;
            end else if (ce) begin
                m_owner = 1; m_grant = 2'b01; m_mem_req = 1;
                m_mem_we = cpu_we; m_mem_addr = cpu_addr; m_mem_wdata = cpu_wdata;
                m_last_dma = 0; m_burst = 0;
                if (de && m_wait < SL) m_wait++;
            end
        end else if (mem_ready) begin
            finish_xfer(mem_rdata);
`ifdef MEM_BUS_TIMEOUT_EN
        end else if (m_timer == TO - 1) begin
            finish_xfer(32'hDEADBEEF);
            m_bus_err = 1;
        end else begin
            m_timer++;
`endif
        end
    endtask

    task automatic check_outputs();
        check_val("grant", grant, m_grant);
        check_val("mem_req", mem_req, m_mem_req);
        check_val("cpu_ack", cpu_ack, m_cpu_ack);
        check_val("dma_ack", dma_ack, m_dma_ack);
        check_val("cpu_rdata", cpu_rdata, m_cpu_rdata);
        check_val("dma_rdata", dma_rdata, m_dma_rdata);
        check_val("bus_err", bus_err, m_bus_err);
        check_val("cpu_stall", cpu_stall, cpu_req & ~m_cpu_ack);
        if (m_mem_req) begin
            check_val("mem_we", mem_we, m_mem_we);
            check_val("mem_addr", mem_addr, m_mem_addr);
            check_val("mem_wdata", mem_wdata, m_mem_wdata);
        end
    endtask

    // One clock cycle: check mid-cycle, then advance the model past the rising edge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        model_advance();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Requesters only raise a fresh request in idle, ack-free cycles so both contend evenly.
    task automatic contend_run(input bit lock, input int n_grants);
        int idx = 0;
        int nb  = lock ? MB : 1;
        bit idle_free;
        dma_lock = lock; mem_ready = 1; cpu_we = 0; dma_we = 1;
        for (int cyc = 0; cyc < 400 && idx < n_grants; cyc++) begin
            idle_free = (m_owner == 0) && !m_cpu_ack && !m_dma_ack;
            cpu_req   = (m_owner == 1) || idle_free;
            dma_req   = (m_owner == 2) || idle_free;
            cpu_addr  = $urandom; dma_addr = $urandom; dma_wdata = $urandom;
            mem_rdata = $urandom;
            step();
            if (idle_free && m_owner != 0) begin
                check_val(lock ? "burst_seq" : "starve_seq", grant,
                          ((idx % (SL + nb)) < SL) ? 2'b01 : 2'b10);
                idx++;
            end
        end
        check_val("contend_budget", idx, n_grants);
        cpu_req = 0; dma_req = 0; dma_lock = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_lock = 0; dma_addr = '0; dma_wdata = '0;
        mem_rdata = '0; mem_ready = 0;
        do_reset();

        // CPU read with minimum latency
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4000_0010; mem_rdata = 32'h1234_5678;
        step();
        check_val("t1_mem_req", mem_req, 1'b1);
        check_val("t1_mem_addr", mem_addr, 32'h4000_0010);
        mem_ready = 1;
        step();
        check_val("t1_ack", cpu_ack, 1'b1);
        check_val("t1_rdata", cpu_rdata, 32'h1234_5678);
        cpu_req = 0; mem_ready = 0;
        repeat (2) step();

        // Starvation promotion, then locked DMA bursts
        do_reset();
        contend_run(1'b0, 2 * (SL + 1));
        do_reset();
        contend_run(1'b1, 2 * (SL + MB));

        // Reset while a DMA transfer is waiting on memory
        do_reset();
        dma_req = 1; dma_we = 1; dma_addr = 32'h0000_0100; dma_wdata = 32'hCAFE_0001; mem_ready = 0;
        repeat (2) step();
        check_val("t4_pre_req", mem_req, 1'b1);
        check_val("t4_pre_grant", grant, 2'b10);
        dma_req = 0;
        do_reset();
        mem_ready = 1;
        cnt = 0;
        repeat (4) begin
            step();
            if (dma_ack) cnt++;
        end
        check_val("t4_no_ack", cnt, 0);
        mem_ready = 0;

        // CPU drops its request mid-transfer
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0000_2000; cpu_wdata = 32'h0BAD_F00D;
        repeat (2) step();
        cpu_req = 0;
        step();
        mem_ready = 1; mem_rdata = 32'h5555_AAAA;
        cnt = 0;
        repeat (6) begin
            step();
            if (cpu_ack) cnt++;
        end
        check_val("t5_acks", cnt, 1);
        check_val("t5_no_reissue", mem_req, 1'b0);
        mem_ready = 0;

        // Memory never answers
        do_reset();
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0000_3000;
        cnt = 0;
        repeat (TO + 16) begin
            step();
            if (bus_err) cnt++;
        end
`ifdef MEM_BUS_TIMEOUT_EN
        check_val("t6_bus_err", cnt, 1);
`else
        check_val("t6_stall", cpu_stall, 1'b1);
        check_val("t6_no_err", cnt, 0);
`endif
        cpu_req = 0;

        // Randomised traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (m_cpu_ack || (!cpu_req && $urandom_range(0, 3) == 0)) begin
                cpu_req = m_cpu_ack ? 1'($urandom_range(0, 1)) : 1'b1;
                cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_wdata = $urandom;
            end else if (cpu_req && m_owner == 1 && $urandom_range(0, 15) == 0) begin
                cpu_req = 0;
            end
            if (m_dma_ack || (!dma_req && $urandom_range(0, 3) == 0)) begin
                dma_req = m_dma_ack ? 1'($urandom_range(0, 1)) : 1'b1;
                dma_we = 1'($urandom_range(0, 1)); dma_addr = $urandom; dma_wdata = $urandom;
                dma_lock = 1'($urandom_range(0, 1));
            end else if (dma_req && m_owner == 2 && $urandom_range(0, 15) == 0) begin
                dma_req = 0;
            end
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
